// File: rtl/sync_fifo_param.sv
// Single-clock FIFO of any depth with FWFT or registered read, programmable
// almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter bit FWFT       = 1'b1,
    parameter int AFULL_LVL  = 6,
    parameter int AEMPTY_LVL = 2,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL  = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] CNT_AEMPTY = CNT_W'(AEMPTY_LVL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  full_s, empty_s;
    logic                  push_ok_s, pop_ok_s;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Status flags and acceptance, all from the registered occupancy.
    always_comb begin
        full_s       = (count_q == CNT_FULL);
        empty_s      = (count_q == {CNT_W{1'b0}});
        push_ok_s    = push & ~full_s;
        pop_ok_s     = pop & ~empty_s;
        full         = full_s;
        empty        = empty_s;
        almost_full  = (count_q >= CNT_AFULL);
        almost_empty = (count_q <= CNT_AEMPTY);
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        if (push_ok_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A fresh error outranks a clear in the same cycle.
        if (push & full_s) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (pop & empty_s) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array, intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head of queue is presented directly from storage.
            always_comb begin
                rd_data  = mem_q[rd_ptr_q];
                rd_valid = ~empty_s;
            end
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
            logic                  rd_valid_q, rd_valid_d;

            // Registered read: data lands one cycle after an accepted pop.
            always_comb begin
                if (pop_ok_s) begin
                    rd_data_d  = mem_q[rd_ptr_q];
                    rd_valid_d = 1'b1;
                end else begin
                    rd_data_d  = rd_data_q;
                    rd_valid_d = 1'b0;
                end
            end

            // Read output registers.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    rd_data_q  <= {DATA_WIDTH{1'b0}};
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            // Drive ports from the read registers.
            always_comb begin
                rd_data  = rd_data_q;
                rd_valid = rd_valid_q;
            end
        end
    endgenerate

endmodule
